// File: rtl/node_activity_monitor.sv
// Windowed activity monitor for one observed node. It counts sample-to-sample toggles and
// rare-value samples over a captured window, and returns the counts plus a threshold alarm.
module node_activity_monitor #(
  parameter int WIN_W    = 16,
  parameter int CNT_W    = 12,
  parameter bit RARE_VAL = 1'b0
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             node_in,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] rare_cnt,
  output logic             alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_ZERO = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             s_r;
  logic             prev_r;
  logic [WIN_W-1:0] win_r;
  logic [CNT_W-1:0] thresh_r;
  logic [CNT_W-1:0] toggle_nxt_s;
  logic [CNT_W-1:0] rare_nxt_s;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != CNT_MAX)) begin
      sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_inc = v;
    end
  endfunction

  // Next counter values for the current RUN sample; also feed the alarm decision.
  always_comb begin
    toggle_nxt_s = sat_inc(toggle_cnt, s_r != prev_r);
    rare_nxt_s   = sat_inc(rare_cnt, s_r == RARE_VAL);
  end

  // Input sample register, free-running in every state.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      s_r <= 1'b0;
    end else begin
      s_r <= node_in;
    end
  end

  // Window control FSM with registered status and result outputs.
  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      state_r    <= IDLE;
      prev_r     <= 1'b0;
      win_r      <= WIN_ZERO;
      thresh_r   <= CNT_ZERO;
      toggle_cnt <= CNT_ZERO;
      rare_cnt   <= CNT_ZERO;
      alarm      <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            win_r      <= win_len;
            thresh_r   <= thresh;
            toggle_cnt <= CNT_ZERO;
            rare_cnt   <= CNT_ZERO;
            alarm      <= 1'b0;
            if (win_len == WIN_ZERO) begin
              state_r   <= HOLD;
              res_valid <= 1'b1;
            end else begin
              state_r <= PRIME;
              busy    <= 1'b1;
            end
          end
        end
        PRIME: begin
          if (abort) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            toggle_cnt <= CNT_ZERO;
            rare_cnt   <= CNT_ZERO;
          end else begin
            prev_r  <= s_r;
            state_r <= RUN;
          end
        end
        RUN: begin
          // Abort takes priority, even on the final window edge.
          if (abort) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            toggle_cnt <= CNT_ZERO;
            rare_cnt   <= CNT_ZERO;
          end else begin
            win_r      <= win_r - WIN_ONE;
            toggle_cnt <= toggle_nxt_s;
            rare_cnt   <= rare_nxt_s;
            prev_r     <= s_r;
            if (win_r == WIN_ONE) begin
              state_r   <= HOLD;
              busy      <= 1'b0;
              res_valid <= 1'b1;
              alarm     <= (thresh_r != CNT_ZERO) && (rare_nxt_s >= thresh_r);
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            state_r   <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
